dcache_st_buffer_drain_ctrl: RTL and testbench

//  Schedules the data cache's single request port between the load pipeline and

---
 rtl/dcache_st_buffer_drain_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dcache_st_buffer_drain_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_st_buffer_drain_ctrl.sv
// Store-buffer drain controller: arbitrates the single dcache request port
// between load pass-through and store drains (one store outstanding at a time).
module dcache_st_buffer_drain_ctrl #(
   parameter int unsigned ADDR_W            = 32,
   parameter int unsigned DATA_W            = 128,
   parameter int unsigned LINE_OFF_W        = 4,
   parameter int unsigned IDLE_DRAIN_CYCLES = 2,
   parameter int unsigned MAX_LD_STREAK     = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sb_empty,
   input  logic                i_sb_full,
   input  logic [ADDR_W-1:0]   i_sb_head_addr,
   input  logic [DATA_W-1:0]   i_sb_head_data,
   input  logic [DATA_W/8-1:0] i_sb_head_be,
   output logic                o_sb_pop,
   input  logic                i_ld_req_valid,
   input  logic [ADDR_W-1:0]   i_ld_req_addr,
   output logic                o_ld_req_ready,
   output logic                o_dc_req_valid,
   output logic                o_dc_req_store,
   output logic [ADDR_W-1:0]   o_dc_req_addr,
   output logic [DATA_W-1:0]   o_dc_req_data,
   output logic [DATA_W/8-1:0] o_dc_req_be,
   input  logic                i_dc_req_ready,
   input  logic                i_dc_st_ack,
   input  logic                i_flush_req,
   output logic                o_flush_done,
   output logic                o_drain_busy
);

   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned IDLE_W = (IDLE_DRAIN_CYCLES > 0) ? $clog2(IDLE_DRAIN_CYCLES + 1) : 1;
   localparam int unsigned STRK_W = $clog2(MAX_LD_STREAK + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_DRAIN_CYCLES);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_LD_STREAK);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_hold_addr;
   logic [DATA_W-1:0]   r_hold_data;
   logic [BE_W-1:0]     r_hold_be;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic [STRK_W-1:0]   r_ld_streak;
   logic                r_flush_active;
   logic                r_flush_done;

   logic                w_flush_eff;
   logic                w_force;
   logic                w_opp;
   logic                w_line_hit;
   logic                w_flush_fin;
   logic                w_pop;
   logic                w_ld_ready;
   logic                w_dc_valid;
   logic                w_dc_store;
   logic [ADDR_W-1:0]   w_dc_addr;
   logic [DATA_W-1:0]   w_dc_data;
   logic [BE_W-1:0]     w_dc_be;

   // A flush request acts in the cycle it arrives; a repeat while active is a no-op.
   assign w_flush_eff = r_flush_active | i_flush_req;
   assign w_force     = i_sb_full | w_flush_eff | (r_ld_streak == STRK_MAX);
   assign w_opp       = ~i_ld_req_valid & (r_idle_cnt >= IDLE_MAX);
   assign w_line_hit  = (i_ld_req_addr[ADDR_W-1:LINE_OFF_W] == r_hold_addr[ADDR_W-1:LINE_OFF_W]);
   assign w_flush_fin = w_flush_eff & i_sb_empty & (r_state == ST_IDLE);

   // Next-state and port muxing; loads only reach the cache when no drain claims it.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_ld_ready  = 1'b0;
      w_dc_valid  = 1'b0;
      w_dc_store  = 1'b0;
      w_dc_addr   = '0;
      w_dc_data   = '0;
      w_dc_be     = '0;
      case (r_state)
         ST_IDLE: begin
            if (~i_sb_empty & (w_force | w_opp)) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_ISSUE;
            end else begin
               w_dc_valid = i_ld_req_valid;
               w_dc_addr  = i_ld_req_addr;
               w_ld_ready = i_ld_req_valid & i_dc_req_ready;
            end
         end
         ST_ISSUE: begin
            w_dc_valid = 1'b1;
            w_dc_store = 1'b1;
            w_dc_addr  = r_hold_addr;
            w_dc_data  = r_hold_data;
            w_dc_be    = r_hold_be;
            if (i_dc_req_ready) begin
               w_state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (i_dc_st_ack) begin
               w_state_nxt = ST_IDLE;
            end else if (~w_line_hit) begin
               w_dc_valid = i_ld_req_valid;
               w_dc_addr  = i_ld_req_addr;
               w_ld_ready = i_ld_req_valid & i_dc_req_ready;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Holding register for the store in flight, loaded on pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold_addr <= '0;
         r_hold_data <= '0;
         r_hold_be   <= '0;
      end else if (w_pop) begin
         r_hold_addr <= i_sb_head_addr;
         r_hold_data <= i_sb_head_data;
         r_hold_be   <= i_sb_head_be;
      end
   end

   // Load-free IDLE cycle counter for opportunistic drains.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idle_cnt <= '0;
      end else if ((r_state != ST_IDLE) || (w_state_nxt != ST_IDLE) || i_ld_req_valid) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt < IDLE_MAX) begin
         r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
   end

   // Consecutive load grants while stores wait; saturates to force a drain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ld_streak <= '0;
      end else if (w_pop || i_sb_empty) begin
         r_ld_streak <= '0;
      end else if (w_ld_ready && (r_ld_streak != STRK_MAX)) begin
         r_ld_streak <= r_ld_streak + STRK_W'(1);
      end
   end

   // Flush tracking; completion pulses the cycle after the buffer is seen empty in IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flush_active <= 1'b0;
         r_flush_done   <= 1'b0;
      end else begin
         r_flush_active <= w_flush_eff & ~w_flush_fin;
         r_flush_done   <= w_flush_fin;
      end
   end

   // Hold every output low while reset is asserted, including the load pass-through.
   assign o_sb_pop       = i_rst_n & w_pop;
   assign o_ld_req_ready = i_rst_n & w_ld_ready;
   assign o_dc_req_valid = i_rst_n & w_dc_valid;
   assign o_dc_req_store = i_rst_n & w_dc_store;
   assign o_dc_req_addr  = i_rst_n ? w_dc_addr : '0;
   assign o_dc_req_data  = i_rst_n ? w_dc_data : '0;
   assign o_dc_req_be    = i_rst_n ? w_dc_be   : '0;
   assign o_flush_done   = r_flush_done;
   assign o_drain_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dcache_st_buffer_drain_ctrl.sv
// Scoreboard bench for the store-buffer drain controller.
module tb_dcache_st_buffer_drain_ctrl;

   localparam int unsigned AW       = 32;
   localparam int unsigned DW       = 128;
   localparam int unsigned BW       = DW / 8;
   localparam int unsigned SB_DEPTH = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
      int            cyc;
      int            nld;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } sbe_t;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_sb_empty;
   logic          i_sb_full;
   logic [AW-1:0] i_sb_head_addr;
   logic [DW-1:0] i_sb_head_data;
   logic [BW-1:0] i_sb_head_be;
   logic          o_sb_pop;
   logic          i_ld_req_valid;
   logic [AW-1:0] i_ld_req_addr;
   logic          o_ld_req_ready;
   logic          o_dc_req_valid;
   logic          o_dc_req_store;
   logic [AW-1:0] o_dc_req_addr;
   logic [DW-1:0] o_dc_req_data;
   logic [BW-1:0] o_dc_req_be;
   logic          i_dc_req_ready;
   logic          i_dc_st_ack;
   logic          i_flush_req;
   logic          o_flush_done;
   logic          o_drain_busy;

   logic          auto_ack;
   logic          man_ack;
   int            ack_lat;
   int            ack_cnt;
   int            cyc;
   int            ld_since_pop;
   int            n_tests;
   int            n_fail;
   logic          sb_pop_seen;

   sbe_t sbq[$];
   exp_t q_pop[$];
   exp_t q_st[$];
   exp_t q_ld[$];
   int   q_fd[$];

   dcache_st_buffer_drain_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .LINE_OFF_W(4), .IDLE_DRAIN_CYCLES(2), .MAX_LD_STREAK(8)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_sb_empty(i_sb_empty), .i_sb_full(i_sb_full),
      .i_sb_head_addr(i_sb_head_addr), .i_sb_head_data(i_sb_head_data),
      .i_sb_head_be(i_sb_head_be), .o_sb_pop(o_sb_pop),
      .i_ld_req_valid(i_ld_req_valid), .i_ld_req_addr(i_ld_req_addr),
      .o_ld_req_ready(o_ld_req_ready),
      .o_dc_req_valid(o_dc_req_valid), .o_dc_req_store(o_dc_req_store),
      .o_dc_req_addr(o_dc_req_addr), .o_dc_req_data(o_dc_req_data),
      .o_dc_req_be(o_dc_req_be), .i_dc_req_ready(i_dc_req_ready),
      .i_dc_st_ack(i_dc_st_ack), .i_flush_req(i_flush_req),
      .o_flush_done(o_flush_done), .o_drain_busy(o_drain_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   assign i_dc_st_ack = auto_ack | man_ack;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_sb();
      i_sb_empty = (sbq.size() == 0);
      i_sb_full  = (sbq.size() >= SB_DEPTH);
      if (sbq.size() > 0) begin
         i_sb_head_addr = sbq[0].addr;
         i_sb_head_data = sbq[0].data;
         i_sb_head_be   = sbq[0].be;
      end else begin
         i_sb_head_addr = '0;
         i_sb_head_data = '0;
         i_sb_head_be   = '0;
      end
   endtask

   task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b,
                             input int pop_cyc, input int st_cyc, input int nld);
      exp_t e;
      sbe_t s;
      s.addr = a; s.data = d; s.be = b;
      sbq.push_back(s);
      drive_sb();
      e.addr = a; e.data = d; e.be = b; e.cyc = pop_cyc; e.nld = nld;
      q_pop.push_back(e);
      e.cyc = st_cyc; e.nld = -1;
      q_st.push_back(e);
   endtask

   task automatic expect_load(input logic [AW-1:0] a);
      exp_t e;
      e.addr = a; e.data = '0; e.be = '0; e.cyc = -1; e.nld = -1;
      q_ld.push_back(e);
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, "_ctl"}, 128'({o_sb_pop, o_ld_req_ready, o_dc_req_valid, o_dc_req_store,
                                 o_flush_done, o_drain_busy}), 128'(0));
      chk({name, "_addr"}, 128'(o_dc_req_addr), 128'(0));
      chk({name, "_data"}, o_dc_req_data, 128'(0));
      chk({name, "_be"}, 128'(o_dc_req_be), 128'(0));
   endtask

   task automatic wait_wait_ack(input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step();
         if (o_drain_busy && !o_dc_req_store) hit = 1'b1;
      end
      if (!hit) fail_now(name);
   endtask

   task automatic wait_drained(input int budget, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (q_pop.size() == 0 && q_st.size() == 0 && q_ld.size() == 0 &&
             q_fd.size() == 0 && !o_drain_busy) ok = 1'b1;
      end
      if (!ok) fail_now(name);
   endtask

   // Store buffer model: the head leaves just after an edge that saw sb_pop.
   always begin
      @(posedge i_clk);
      sb_pop_seen = o_sb_pop;
      #1;
      if (sb_pop_seen && sbq.size() > 0) void'(sbq.pop_front());
      drive_sb();
   end

   // Ack responder: acks ack_lat cycles after a store is accepted (0 = manual).
   always begin
      @(posedge i_clk);
      #1;
      auto_ack = 1'b0;
      if (ack_cnt > 0) begin
         ack_cnt--;
         if (ack_cnt == 0) auto_ack = 1'b1;
      end
      @(negedge i_clk);
      if (i_rst_n && o_dc_req_valid && o_dc_req_store && i_dc_req_ready && ack_lat > 0)
         ack_cnt = ack_lat;
   end

   // Monitor: compares every observed pop, handshake and flush_done against the queues.
   always @(negedge i_clk) begin
      exp_t e;
      if (o_sb_pop) begin
         if (q_pop.size() == 0) fail_now("unexpected_sb_pop");
         else begin
            e = q_pop.pop_front();
            chk("pop_nonempty", 128'(i_sb_empty), 128'(0));
            chk("pop_head_addr", 128'(i_sb_head_addr), 128'(e.addr));
            if (e.cyc >= 0) chk("pop_cycle", 128'(cyc), 128'(e.cyc));
            if (e.nld >= 0) chk("pop_after_loads", 128'(ld_since_pop), 128'(e.nld));
         end
         ld_since_pop = 0;
      end
      if (o_dc_req_valid && i_dc_req_ready) begin
         if (o_dc_req_store) begin
            if (q_st.size() == 0) fail_now("unexpected_store_req");
            else begin
               e = q_st.pop_front();
               chk("st_addr", 128'(o_dc_req_addr), 128'(e.addr));
               chk("st_data", o_dc_req_data, e.data);
               chk("st_be", 128'(o_dc_req_be), 128'(e.be));
               if (e.cyc >= 0) chk("st_cycle", 128'(cyc), 128'(e.cyc));
            end
         end else begin
            if (q_ld.size() == 0) fail_now("unexpected_load_req");
            else begin
               e = q_ld.pop_front();
               chk("ld_addr", 128'(o_dc_req_addr), 128'(e.addr));
               chk("ld_data_be_zero", 128'({o_dc_req_data[15:0], o_dc_req_be}), 128'(0));
               chk("ld_ready", 128'(o_ld_req_ready), 128'(1));
            end
            ld_since_pop++;
         end
      end
      if (o_ld_req_ready && !(o_dc_req_valid && i_dc_req_ready && !o_dc_req_store))
         fail_now("ld_ready_without_grant");
      if (o_flush_done) begin
         if (q_fd.size() == 0) fail_now("unexpected_flush_done");
         else chk("flush_done_cycle", 128'(cyc), 128'(q_fd.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int f;
      int g;
      bit seen;
      bit done;
      n_tests = 0; n_fail = 0; ld_since_pop = 0;
      auto_ack = 1'b0; man_ack = 1'b0; ack_lat = 2; ack_cnt = 0;
      i_rst_n = 1'b0; i_flush_req = 1'b0; i_dc_req_ready = 1'b1;
      i_ld_req_valid = 1'b1; i_ld_req_addr = 32'h0000_1234;
      drive_sb();

      // Reset with a load requesting and a store buffered: outputs stay low.
      // Opportunistic drain then pops on the third cycle after release, issues on the fourth.
      push_store(32'h0000_0100, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 16'hffff, 2, 3, -1);
      repeat (3) step();
      chk_outputs_zero("reset");
      i_ld_req_valid = 1'b0;
      step();
      i_rst_n = 1'b1;
      wait_drained(30, "drain_opportunistic");

      // Continuous loads hold off the drain for exactly 8 grants; stalled until ack.
      ack_lat = 3;
      i_ld_req_valid = 1'b1;
      i_ld_req_addr  = 32'h0000_2004;
      push_store(32'h0000_2000, 128'hcafe_0000_0000_0000_0000_0000_0000_0001, 16'h000f, -1, -1, 8);
      for (int i = 0; i < 8; i++) expect_load(32'h0000_2004);
      seen = 1'b0; done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         step();
         if (o_drain_busy) begin
            seen = 1'b1;
            chk("streak_ld_blocked", 128'(o_ld_req_ready), 128'(0));
         end else if (seen) begin
            i_ld_req_valid = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) fail_now("streak_drain_timeout");
      wait_drained(20, "streak_drain");

      // Full buffer with a load in the same cycle: drain wins, then age-ordered drains.
      ack_lat = 2;
      i_ld_req_valid = 1'b1;
      i_ld_req_addr  = 32'h0000_5000;
      push_store(32'h0000_4000, 128'h1, 16'h0001, -1, -1, 0);
      push_store(32'h0000_4100, 128'h2, 16'h0003, -1, -1, -1);
      push_store(32'h0000_4200, 128'h3, 16'h0007, -1, -1, -1);
      push_store(32'h0000_4300, 128'h4, 16'h000f, -1, -1, -1);
      @(negedge i_clk);
      chk("full_pop", 128'(o_sb_pop), 128'(1));
      chk("full_ld_ready", 128'(o_ld_req_ready), 128'(0));
      step();
      i_ld_req_valid = 1'b0;
      wait_drained(100, "full_drain");

      // Same-line load stalls during WAIT_ACK, other line passes, none granted on the ack cycle.
      ack_lat = 0;
      push_store(32'h0000_1000, 128'hdead_beef_0000_0000_0000_0000_0000_1000, 16'h00ff, -1, -1, -1);
      wait_wait_ack("reach_wait_ack");
      i_ld_req_valid = 1'b1;
      i_ld_req_addr  = 32'h0000_1008;
      @(negedge i_clk);
      chk("line_hit_ld_ready", 128'(o_ld_req_ready), 128'(0));
      chk("line_hit_dc_valid", 128'(o_dc_req_valid), 128'(0));
      step();
      i_ld_req_addr = 32'h0000_2000;
      expect_load(32'h0000_2000);
      @(negedge i_clk);
      chk("line_miss_ld_ready", 128'(o_ld_req_ready), 128'(1));
      step();
      man_ack = 1'b1;
      @(negedge i_clk);
      chk("ack_cycle_ld_ready", 128'(o_ld_req_ready), 128'(0));
      step();
      man_ack = 1'b0;
      i_ld_req_valid = 1'b0;
      wait_drained(20, "line_stall_drain");

      // Flush of 3 entries: forced pops 4 cycles apart, flush_done 13 cycles after the request.
      ack_lat = 2;
      f = cyc;
      push_store(32'h0000_8000, 128'h8000, 16'h1111, f,     f + 1, -1);
      push_store(32'h0000_8100, 128'h8100, 16'h2222, f + 4, f + 5, -1);
      push_store(32'h0000_8200, 128'h8200, 16'h4444, f + 8, f + 9, -1);
      q_fd.push_back(f + 13);
      i_flush_req = 1'b1;
      step();
      i_flush_req = 1'b0;
      wait_drained(60, "flush_three");

      // Flush on an empty idle buffer completes the next cycle.
      g = cyc;
      q_fd.push_back(g + 1);
      i_flush_req = 1'b1;
      step();
      i_flush_req = 1'b0;
      wait_drained(10, "flush_empty");

      // Reset during WAIT_ACK clears outputs at once; a late ack is ignored afterwards.
      ack_lat = 0;
      push_store(32'h0000_9000, 128'h9000, 16'h8000, -1, -1, -1);
      wait_wait_ack("reset_reach_wait_ack");
      i_rst_n = 1'b0;
      i_ld_req_valid = 1'b1;
      i_ld_req_addr  = 32'h0000_a000;
      #1;
      chk_outputs_zero("reset_mid_drain");
      step();
      step();
      i_ld_req_valid = 1'b0;
      i_rst_n = 1'b1;
      step();
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      @(negedge i_clk);
      chk("late_ack_busy", 128'(o_drain_busy), 128'(0));
      chk("late_ack_dc_valid", 128'(o_dc_req_valid), 128'(0));
      ack_lat = 2;
      step();
      push_store(32'h0000_b000, 128'hb000, 16'h0f0f, -1, -1, -1);
      wait_drained(30, "post_reset_drain");

      chk("leftover_expectations", 128'(q_pop.size() + q_st.size() + q_ld.size() + q_fd.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
